wb_switch_n: RTL
================

# wb_switch_n

Parametrised single-master Wishbone switch and address decoder for the Zet SoC. It generalises the fixed 12-slave switch to N slaves with configurable address and data widths. Slave selection is registered at the start of each cycle and held for the whole transfer, and acknowledge and read data come only from the selected slave. It sits between the Zet CPU bus (or the bus arbiter output) and the peripheral/memory slaves, and adds an optional watchdog that terminates transfers to unresponsive slaves.

## Interface

Parameters:
- NS, 12, number of slaves (2..32); slave NS-1 is the default slave.
- AW, 20, word address width (master address bits [AW:1]).
- DW, 16, data width; must be a multiple of 8. Select width SW = DW/8.
- ADDR, {NS{AW'h0}}, packed match addresses; slice i = slave i.
- MASK, {NS{AW'h0}}, packed match masks; slice i = slave i. A zero mask never matches, except for the default slave, whose entry is ignored.
- TIMEOUT, 255, watchdog limit in cycles (1..65535). Only used with the watchdog compiled in.
- ERR_DATA, {DW{1'b1}}, read data returned on a timeout.

Ports:
- wb_clk_i  in  1  bus clock; all state updates on the rising edge.
- wb_rst_n_i  in  1  reset; one clock, reset is synchronous and active-low.
- m_dat_i  in  DW  master write data.
- m_dat_o  out  DW  read data to the master.
- m_adr_i  in  AW  master word address.
- m_sel_i  in  SW  byte selects.
- m_we_i  in  1  write enable.
- m_cyc_i  in  1  cycle valid.
- m_stb_i  in  1  strobe.
- m_ack_o  out  1  transfer acknowledge.
- s_dat_o  out  DW  write data, broadcast to all slaves.
- s_adr_o  out  AW  address, broadcast to all slaves.
- s_sel_o  out  SW  byte selects, broadcast to all slaves.
- s_we_o  out  1  write enable, broadcast to all slaves.
- s_cyc_o  out  NS  per-slave cyc; only the latched slave's bit is set, while busy.
- s_stb_o  out  NS  per-slave strobe.
- s_dat_i  in  NS*DW  packed slave read data.
- s_ack_i  in  NS  slave acknowledges.
- timeout_o  out  1  one-cycle pulse when the watchdog terminates a transfer.
- sel_o  out  log2(NS)  index of the latched slave, for debug.

## Operation

State machine states are IDLE, BUSY and RECOVER.

Decode (combinational, evaluated in IDLE only):
- Slave i matches when (m_adr_i & MASK[i]) == ADDR[i] and MASK[i] != 0.
- The lowest matching index wins.
- If nothing matches, the default slave NS-1 is selected.

IDLE:
- When m_cyc_i & m_stb_i: latch the winning index into sel_q, clear the watchdog counter, go to BUSY.
- No slave strobes are driven in IDLE.

BUSY:
- s_stb_o[sel_q] = m_cyc_i & m_stb_i; s_cyc_o[sel_q] = m_cyc_i. All other bits are 0.
- m_ack_o = s_ack_i[sel_q]; m_dat_o = s_dat_i[sel_q].
- Acks from non-selected slaves are ignored.
- On s_ack_i[sel_q], go to IDLE.
- If m_cyc_i drops (master abort), go to IDLE with no ack.
- If the watchdog reaches TIMEOUT, go to RECOVER.

RECOVER (one cycle):
- m_ack_o = 1, m_dat_o = ERR_DATA, timeout_o = 1, all s_stb_o/s_cyc_o = 0. Then go to IDLE.

Other rules:
- Broadcast outputs pass through combinationally from the master.
- When idle, m_dat_o = 0.
- Reset (mid-transfer included) forces IDLE, sel_q = 0 and counter = 0. Every strobe, cyc, ack and timeout output is 0 in the reset cycle and the cycle after.

## Timing

- Decode latency is 1 cycle: the master strobe is seen at edge k, and the slave strobe is asserted from cycle k+1.
- Ack is combinational from slave to master, 0 added cycles. A zero-wait slave completes in 2 cycles.
- There is 1 IDLE cycle minimum between back-to-back transfers, so that each new address is re-decoded.
- The watchdog counts BUSY cycles without an ack. RECOVER is entered after exactly TIMEOUT BUSY cycles.
- An ack arriving in the same cycle the counter hits TIMEOUT counts as a normal ack: no timeout.
- sel_q is stable for the whole transfer, even if m_adr_i changes mid-cycle.

## Configuration

WB_SWITCH_TIMEOUT_EN:
- Defined: the watchdog counter (16 bits) and the RECOVER state exist.
- Undefined: no counter; BUSY waits indefinitely; timeout_o is tied 0. The TIMEOUT and ERR_DATA parameters are unused.

## Structure

- Package wb_switch_pkg holds the state encoding (IDLE=2'd0, BUSY=2'd1, RECOVER=2'd2), the clog2 helper and the default TIMEOUT constant.
- One sub-module: wb_addr_decode, the combinational priority match, parametrised by NS/AW/ADDR/MASK. It outputs the index and a match-found flag.

## Test plan

1. NS=4, ADDR[0]=h00000/MASK[0]=hF0000, ADDR[1]=hA0000/MASK[1]=hE0000. Read address hA1234 -> s_stb_o=4'b0010 at cycle k+1; slave 1 acks with hBEEF -> m_ack_o=1, m_dat_o=hBEEF in that cycle.
2. Overlapping matches on slaves 0 and 2 -> slave 0 is chosen. Unmapped address hF0000 -> default slave 3 is strobed.
3. Slave 2 asserts a spurious ack while slave 1 is busy -> m_ack_o stays 0. The data written by the master appears unchanged on s_dat_o.
4. Watchdog on, TIMEOUT=8, silent slave -> after 8 BUSY cycles: m_ack_o=1, m_dat_o=hFFFF, timeout_o pulses once, strobes drop; the next transfer decodes normally.
5. wb_rst_n_i low in mid-BUSY -> the next cycle has all strobes 0, state IDLE, sel_o=0. The master drops cyc mid-BUSY -> IDLE with no ack.

Source files
------------

// File: rtl/wb_switch_pkg.sv
// Shared definitions for the parametrised Wishbone switch: FSM encoding,
// the index-width helper and the default watchdog limit.
package wb_switch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Bits needed to index 'value' items; at least 1 for value >= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority address match: lowest matching slave index wins.
// The last slave is the default and its map entry never takes part in matching.
module wb_addr_decode
    import wb_switch_pkg::*;
#(
    parameter int               NS   = 12,
    parameter int               AW   = 20,
    parameter logic [NS*AW-1:0] ADDR = '0,
    parameter logic [NS*AW-1:0] MASK = '0,
    localparam int              SELW = clog2(NS)
) (
    input  logic [AW-1:0]   adr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [NS-1:0] match;

    for (genvar gi = 0; gi < NS; gi++) begin : g_match
        if (gi == NS - 1) begin : g_default
            assign match[gi] = 1'b0;
        end else begin : g_slave
            localparam logic [AW-1:0] SLAVE_ADDR = ADDR[gi*AW +: AW];
            localparam logic [AW-1:0] SLAVE_MASK = MASK[gi*AW +: AW];
            // A zero mask would match everything, so it is treated as "unmapped".
            assign match[gi] = (SLAVE_MASK != '0) && ((adr & SLAVE_MASK) == SLAVE_ADDR);
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx   = SELW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_switch_n.sv
// Single-master Wishbone switch for NS slaves with a registered slave select.
// Optional watchdog (RECOVER state, timeout_o) is built when WB_SWITCH_TIMEOUT_EN is defined.
module wb_switch_n
    import wb_switch_pkg::*;
#(
    parameter int               NS       = 12,
    parameter int               AW       = 20,
    parameter int               DW       = 16,
    parameter logic [NS*AW-1:0] ADDR     = '0,
    parameter logic [NS*AW-1:0] MASK     = '0,
    parameter int               TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [DW-1:0]    ERR_DATA = '1,
    localparam int              SW       = DW / 8,
    localparam int              SELW     = clog2(NS)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [DW-1:0]    m_dat_i,
    output logic [DW-1:0]    m_dat_o,
    input  logic [AW-1:0]    m_adr_i,
    input  logic [SW-1:0]    m_sel_i,
    input  logic             m_we_i,
    input  logic             m_cyc_i,
    input  logic             m_stb_i,
    output logic             m_ack_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [SW-1:0]    s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*DW-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic             timeout_o,
    output logic [SELW-1:0]  sel_o
);

    state_t          state_reg;
    state_t          state_next;
    logic [SELW-1:0] sel_reg;
    logic [SELW-1:0] sel_next;
    logic [SELW-1:0] dec_idx;
    logic            dec_found;
    logic            start;
    logic            ack_sel;
    logic            expired;
    logic [DW-1:0]   slave_data [NS];

    wb_addr_decode #(
        .NS   (NS),
        .AW   (AW),
        .ADDR (ADDR),
        .MASK (MASK)
    ) u_decode (
        .adr   (m_adr_i),
        .idx   (dec_idx),
        .found (dec_found)
    );

    for (genvar gi = 0; gi < NS; gi++) begin : g_unpack
        assign slave_data[gi] = s_dat_i[gi*DW +: DW];
    end

    assign start    = m_cyc_i & m_stb_i;
    assign ack_sel  = s_ack_i[sel_reg];
    assign sel_next = dec_found ? dec_idx : SELW'(NS - 1);

    assign s_dat_o = m_dat_i;
    assign s_adr_o = m_adr_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign sel_o   = sel_reg;

`ifdef WB_SWITCH_TIMEOUT_EN
    logic [15:0] cnt_reg;

    // expired is high during the TIMEOUT-th BUSY cycle; an ack in that cycle still wins.
    assign expired = (cnt_reg == 16'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || state_reg != BUSY) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                sel_reg <= sel_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_sel || !m_cyc_i) begin
                    state_next = IDLE;
                end else if (expired) begin
                    state_next = RECOVER;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even if the state is still BUSY.
    always_comb begin
        s_stb_o   = '0;
        s_cyc_o   = '0;
        m_ack_o   = 1'b0;
        m_dat_o   = '0;
        timeout_o = 1'b0;
        if (wb_rst_n_i) begin
            case (state_reg)
                BUSY: begin
                    s_stb_o[sel_reg] = m_cyc_i & m_stb_i;
                    s_cyc_o[sel_reg] = m_cyc_i;
                    m_ack_o          = ack_sel;
                    m_dat_o          = slave_data[sel_reg];
                end
`ifdef WB_SWITCH_TIMEOUT_EN
                RECOVER: begin
                    m_ack_o   = 1'b1;
                    m_dat_o   = ERR_DATA;
                    timeout_o = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
